// File: rtl/uart_pkg.sv
// Shared register map and bit positions for the UART MMIO front end.
package uart_pkg;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;

    localparam int ST_TX_EMPTY    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;
    localparam int ST_TX_CNT_LSB  = 8;
    localparam int ST_RX_CNT_LSB  = 16;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; push while full and pop while empty are ignored.
module uart_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    // Storage is not reset, so the head is masked to keep dout at zero when empty.
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Register-bus front end for the UART core: TX/RX FIFOs, status, control, irq.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_irq,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready
);

    localparam int TXW = $clog2(TX_DEPTH) + 1;
    localparam int RXW = $clog2(RX_DEPTH) + 1;

    logic [1:0]     r_ctrl;
    logic           r_rx_overrun;
    logic           r_tx_overflow;
    logic [31:0]    r_rdata;
    logic           r_rx_ready;

    logic [1:0]     w_reg;
    logic           w_rd;
    logic           w_wr;
    logic           w_tx_push;
    logic           w_tx_pop;
    logic           w_tx_full;
    logic           w_tx_empty;
    logic [7:0]     w_tx_dout;
    logic [TXW-1:0] w_tx_count;
    logic           w_rx_push;
    logic           w_rx_pop;
    logic           w_rx_full;
    logic           w_rx_empty;
    logic [7:0]     w_rx_dout;
    logic [RXW-1:0] w_rx_count;
    logic [31:0]    w_status;
    logic [31:0]    w_rdata_next;
    logic           w_unused_bits;

    assign w_reg     = bus_addr[3:2];
    assign w_rd      = bus_sel & ~bus_we;
    assign w_wr      = bus_sel & bus_we;
    assign w_tx_push = w_wr & (w_reg == UART_DATA);
    assign w_tx_pop  = tx_valid & tx_ready;
    assign w_rx_push = rx_valid & r_rx_ready;
    assign w_rx_pop  = w_rd & (w_reg == UART_DATA) & ~w_rx_empty;
    assign w_unused_bits = &{1'b0, bus_addr[1:0], bus_wdata[31:8]};

    uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_tx_push),
        .din   (bus_wdata[7:0]),
        .pop   (w_tx_pop),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    uart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_rx_push),
        .din   (rx_data),
        .pop   (w_rx_pop),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    always_comb begin
        w_status = '0;
        w_status[ST_TX_EMPTY]    = w_tx_empty;
        w_status[ST_TX_FULL]     = w_tx_full;
        w_status[ST_RX_NONEMPTY] = ~w_rx_empty;
        w_status[ST_RX_FULL]     = w_rx_full;
        w_status[ST_RX_OVERRUN]  = r_rx_overrun;
        w_status[ST_TX_OVERFLOW] = r_tx_overflow;
        w_status[ST_TX_CNT_LSB +: 8] = 8'(w_tx_count);
        w_status[ST_RX_CNT_LSB +: 8] = 8'(w_rx_count);
    end

    always_comb begin
        w_rdata_next = '0;
        case (w_reg)
            UART_DATA:   w_rdata_next = {24'b0, w_rx_dout};
            UART_STATUS: w_rdata_next = w_status;
            UART_CTRL:   w_rdata_next = {30'b0, r_ctrl};
            default:     w_rdata_next = '0;
        endcase
    end

    // Sticky flags: a same-cycle set beats the write-1-to-clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl        <= '0;
            r_rx_overrun  <= 1'b0;
            r_tx_overflow <= 1'b0;
            r_rdata       <= '0;
            r_rx_ready    <= 1'b0;
        end else begin
            r_rx_ready <= 1'b1;
            if (w_rd)
                r_rdata <= w_rdata_next;
            if (w_wr && w_reg == UART_CTRL)
                r_ctrl <= bus_wdata[1:0];
            if (w_rx_push && w_rx_full)
                r_rx_overrun <= 1'b1;
            else if (w_wr && w_reg == UART_STATUS && bus_wdata[ST_RX_OVERRUN])
                r_rx_overrun <= 1'b0;
            if (w_tx_push && w_tx_full)
                r_tx_overflow <= 1'b1;
            else if (w_wr && w_reg == UART_STATUS && bus_wdata[ST_TX_OVERFLOW])
                r_tx_overflow <= 1'b0;
        end
    end

    assign bus_rdata = r_rdata;
    assign rx_ready  = r_rx_ready;
    assign tx_valid  = ~w_tx_empty;
    assign tx_data   = w_tx_dout;
    assign bus_irq   = (r_ctrl[CTRL_RX_IRQ_EN] & (~w_rx_empty | r_rx_overrun))
                     | (r_ctrl[CTRL_TX_IRQ_EN] & w_tx_empty);

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio with TX/RX scoreboard queues.
module tb_uart_mmio;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bus_sel = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_irq;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready;

    int ncmp = 0;
    int nfail = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_ovr = 1'b0;
    logic       m_ovf = 1'b0;

    uart_mmio #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_irq   (bus_irq),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // TX monitor: a handshake visible at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rstn && tx_valid && tx_ready) begin
            ncmp++;
            assert (txq.size() != 0) else begin
                nfail++;
                $error("FAIL tx_unexpected: observed byte 0x%02h expected none", tx_data);
            end
            if (txq.size() != 0)
                check("tx_byte", {24'b0, tx_data}, {24'b0, txq.pop_front()});
        end
    end

    task automatic bus_write(input logic [1:0] reg_sel, input logic [31:0] data);
        @(posedge clk); #1;
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = {reg_sel, 2'b00}; bus_wdata = data;
        if (reg_sel == 2'd0) begin
            if (txq.size() == 8) m_ovf = 1'b1;
            else txq.push_back(data[7:0]);
        end else if (reg_sel == 2'd1) begin
            if (data[4]) m_ovr = 1'b0;
            if (data[5]) m_ovf = 1'b0;
        end
        @(posedge clk); #1;
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] reg_sel, output logic [31:0] data);
        @(posedge clk); #1;
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = {reg_sel, 2'b00};
        @(posedge clk); #1;
        bus_sel = 1'b0;
        data = bus_rdata;
    endtask

    task automatic read_check(input string tag, input logic [1:0] reg_sel, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(reg_sel, d);
        check(tag, d, exp);
    endtask

    task automatic read_data_check(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = (rxq.size() != 0) ? {24'b0, rxq.pop_front()} : 32'h0;
        bus_read(2'd0, d);
        check(tag, d, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        if (rxq.size() == 8) m_ovr = 1'b1;
        else rxq.push_back(b);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp;
        logic [31:0] d;

        // Reset state
        #12;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        check("rst_irq", {31'b0, bus_irq}, 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        check("rx_ready_up", {31'b0, rx_ready}, 32'h1);
        read_check("status_reset", 2'd1, 32'h0000_0001);
        read_check("reserved_read", 2'd3, 32'h0);

        // Two TX bytes held then drained
        bus_write(2'd0, 32'h41);
        bus_write(2'd0, 32'h42);
        check("tx_valid_held", {31'b0, tx_valid}, 32'h1);
        check("tx_head_held", {24'b0, tx_data}, 32'h41);
        read_check("status_tx2", 2'd1, 32'h0000_0200);
        @(posedge clk); #1 tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 tx_ready = 1'b0;
        check("tx_valid_drained", {31'b0, tx_valid}, 32'h0);

        // TX overflow and W1C
        for (int i = 0; i < 9; i++)
            bus_write(2'd0, 32'h60 + i);
        read_check("status_tx_full_ovf", 2'd1, 32'h0000_0822);
        bus_write(2'd3, 32'hFF);
        bus_write(2'd1, 32'h20);
        read_check("status_ovf_cleared", 2'd1, 32'h0000_0802);
        @(posedge clk); #1 tx_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_ready = 1'b0;
        check("tx_no_ninth", {31'b0, tx_valid}, 32'h0);
        check("tx_scoreboard_empty", txq.size(), 32'h0);

        // RX receive, irq, reads
        rx_pulse(8'h55);
        rx_pulse(8'hAA);
        bus_write(2'd2, 32'h1);
        check("irq_rx", {31'b0, bus_irq}, 32'h1);
        read_check("ctrl_readback", 2'd2, 32'h1);
        read_check("status_rx2", 2'd1, 32'h0002_0005);
        read_data_check("rx_read0");
        check("irq_one_left", {31'b0, bus_irq}, 32'h1);
        read_data_check("rx_read1");
        check("irq_dropped", {31'b0, bus_irq}, 32'h0);
        read_data_check("rx_read_empty");
        read_check("status_rx_empty", 2'd1, 32'h0000_0001);

        // RX full, push a 9th while popping in the same cycle
        for (int i = 0; i < 8; i++)
            rx_pulse(8'h80 + 8'(i));
        read_check("status_rx_full", 2'd1, 32'h0008_000D);
        @(posedge clk); #1;
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 4'h0;
        rx_valid = 1'b1; rx_data = 8'h99;
        if (rxq.size() == 8) m_ovr = 1'b1;
        else rxq.push_back(8'h99);
        exp = {24'b0, rxq.pop_front()};
        @(posedge clk); #1;
        bus_sel = 1'b0; rx_valid = 1'b0;
        check("rx_pop_at_overrun", bus_rdata, exp);
        read_check("status_overrun", 2'd1, 32'h0007_0015);
        for (int i = 0; i < 7; i++)
            read_data_check("rx_drain");
        read_data_check("rx_ninth_absent");
        check("irq_overrun", {31'b0, bus_irq}, 32'h1);
        bus_write(2'd1, 32'h10);
        check("irq_after_w1c", {31'b0, bus_irq}, 32'h0);
        bus_read(2'd1, d);
        exp = 32'h0;
        exp[0] = (txq.size() == 0);
        exp[4] = m_ovr;
        exp[5] = m_ovf;
        check("status_ovr_cleared", d, exp);

        // Asynchronous reset with TX bytes queued
        for (int i = 0; i < 3; i++)
            bus_write(2'd0, 32'hC0 + i);
        read_check("status_tx3", 2'd1, 32'h0000_0300);
        @(posedge clk); #3 rstn = 1'b0;
        #1;
        txq.delete(); rxq.delete(); m_ovr = 1'b0; m_ovf = 1'b0;
        check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async_rx_ready", {31'b0, rx_ready}, 32'h0);
        check("async_rdata", bus_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        read_check("status_after_reset", 2'd1, 32'h0000_0001);
        read_check("ctrl_after_reset", 2'd2, 32'h0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
